// File: rtl/regbank_write_arbiter.sv
// Register bank write arbiter: clears the bank on reset or request, then
// round-robin arbitrates pipeline and debug writes onto one write port.
module regbank_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              regwrite,
  output logic              grant_id,
  output logic              init_done,
  output logic [15:0]       wr_count
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              last_grant;
  logic              run_ok;
  logic              acc0;
  logic              acc1;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  assign run_ok = (state == RUN) && !clear_req;

  // Tie goes to whoever did not win the previous accept.
  assign req0_ready = run_ok && req0_valid
                   && (!req1_valid || last_grant);
  assign req1_ready = run_ok && req1_valid
                   && (!req0_valid || !last_grant);

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;

  assign acc_addr = acc1 ? req1_addr : req0_addr;
  assign acc_data = acc1 ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= INIT;
      clr_cnt        <= '0;
      last_grant     <= 1'b1;
      regwrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      grant_id       <= 1'b0;
      init_done      <= 1'b0;
      wr_count       <= '0;
    end else begin
      regwrite <= 1'b0;
      unique case (state)
        INIT: begin
          regwrite       <= 1'b1;
          write_register <= clr_cnt;
          write_data     <= '0;
          clr_cnt        <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
          end else if (acc0 || acc1) begin
            last_grant <= acc1;
            grant_id   <= acc1;
            // Register zero is hardwired: handshake only.
            if (acc_addr != '0) begin
              regwrite       <= 1'b1;
              write_register <= acc_addr;
              write_data     <= acc_data;
              if (wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        clear_req = 1'b0;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        regwrite;
  logic        grant_id;
  logic        init_done;
  logic [15:0] wr_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regbank_write_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_addr(req0_addr),
    .req0_data(req0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_addr(req1_addr),
    .req1_data(req1_data),
    .clear_req(clear_req),
    .write_register(write_register),
    .write_data(write_data),
    .regwrite(regwrite),
    .grant_id(grant_id),
    .init_done(init_done),
    .wr_count(wr_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_clear(input int upto);
    for (int i = 0; i <= upto; i++) begin
      @(negedge clk);
      check("clr_we", 32'(regwrite), 1);
      check("clr_idx", 32'(write_register), i);
      check("clr_dat", write_data, 0);
      check("clr_done", 32'(init_done), (i == 31) ? 1 : 0);
    end
  endtask

  initial begin
    int exp_reg [4] = '{2, 3, 2, 3};
    int exp_gnt [4] = '{0, 1, 0, 1};

    #2;
    check("rst_we", 32'(regwrite), 0);
    check("rst_reg", 32'(write_register), 0);
    check("rst_dat", write_data, 0);
    check("rst_gnt", 32'(grant_id), 0);
    check("rst_done", 32'(init_done), 0);
    check("rst_cnt", 32'(wr_count), 0);
    check("rst_rdy", {req0_ready, req1_ready}, 0);

    #10 rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1 check("init_rdy", {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_clear(31);

    @(negedge clk);
    check("idle_we", 32'(regwrite), 0);
    check("idle_done", 32'(init_done), 1);
    check("idle_cnt", 32'(wr_count), 0);

    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'd555;
    #1 check("r0_rdy", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    check("r0_we", 32'(regwrite), 1);
    check("r0_reg", 32'(write_register), 1);
    check("r0_dat", write_data, 555);
    check("r0_gnt", 32'(grant_id), 0);
    check("r0_cnt", 32'(wr_count), 1);

    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd777;
    #1 check("z_rdy", {req0_ready, req1_ready}, 2'b01);
    @(negedge clk);
    req1_valid = 1'b0;
    check("z_we", 32'(regwrite), 0);
    check("z_cnt", 32'(wr_count), 1);
    check("z_hold", write_data, 555);

    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'd222;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'd333;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_we", 32'(regwrite), 1);
      check("rr_reg", 32'(write_register), exp_reg[i]);
      check("rr_gnt", 32'(grant_id), exp_gnt[i]);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_cnt", 32'(wr_count), 5);
    req0_addr = 5'd9; req0_data = 32'd999;
    @(negedge clk);
    check("hold_we", 32'(regwrite), 0);
    check("hold_reg", 32'(write_register), 3);
    check("hold_dat", write_data, 333);

    clear_req = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'd444;
    #1 check("clr_rdy", 32'(req0_ready), 0);
    @(negedge clk);
    clear_req = 1'b0;
    check("gap_we", 32'(regwrite), 0);
    check("gap_done", 32'(init_done), 0);
    check("gap_rdy", 32'(req0_ready), 0);
    check_clear(31);
    @(negedge clk);
    req0_valid = 1'b0;
    check("pend_we", 32'(regwrite), 1);
    check("pend_reg", 32'(write_register), 4);
    check("pend_dat", write_data, 444);
    check("pend_cnt", 32'(wr_count), 6);

    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check_clear(10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(regwrite), 0);
    check("arst_reg", 32'(write_register), 0);
    check("arst_done", 32'(init_done), 0);
    check("arst_cnt", 32'(wr_count), 0);
    #1 rst_n = 1'b1;
    check_clear(31);

    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'd50;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'd60;
    #1 check("tie_rdy", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_reg", 32'(write_register), 5);
    check("tie_gnt", 32'(grant_id), 0);
    check("tie_cnt", 32'(wr_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
